// File: rtl/rcu_pkg.sv
// Shared types for the RCU power/reset sequencer: state codes, control bundle, sizing helpers.
// Pure declarations, no timing or flow control of their own.
package rcu_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_CLK_ON   = 3'd1,
    ST_RUN      = 3'd2,
    ST_QUIESCE  = 3'd3,
    ST_RST_ON   = 3'd4,
    ST_CLK_STOP = 3'd5
  } rcu_state_e;

  typedef struct packed {
    logic rsten;
    logic clken;
    logic quiesce_req;
    logic ready;
    logic busy;
  } rcu_ctl_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Smallest counter width able to hold max_val.
  function automatic int cnt_bits(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Control outputs owned by each state; rsten is only ever set together with clken.
  function automatic rcu_ctl_t state_ctl(input rcu_state_e st);
    rcu_ctl_t c;
    c = '0;
    case (st)
      ST_CLK_ON:   begin c.clken = 1'b1; c.busy = 1'b1; end
      ST_RUN:      begin c.rsten = 1'b1; c.clken = 1'b1; c.ready = 1'b1; end
      ST_QUIESCE:  begin c.rsten = 1'b1; c.clken = 1'b1; c.quiesce_req = 1'b1; c.busy = 1'b1; end
      ST_RST_ON:   begin c.clken = 1'b1; c.busy = 1'b1; end
      ST_CLK_STOP: c.busy = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rcu_seq_cnt.sv
// Loadable down-counter with a terminal flag (count == 1); load takes effect next cycle.
// Saturates at zero instead of wrapping; no flow control.
module rcu_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             EXTCLK,
  input  logic             EXTRST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge EXTCLK) begin
    if (EXTRST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/rcu_seq.sv
// Power/reset sequencer for the RCU: orders clock start, reset release, quiesce, reset assert, clock stop.
// All outputs registered, one EXTCLK per transition; quiesce waits on quiesce_ack up to QTIMEOUT cycles.
module rcu_seq
  import rcu_pkg::*;
#(
  parameter int RST_HOLD   = 4,
  parameter int CLK_SETTLE = 2,
  parameter int QTIMEOUT   = 255,
  parameter int CNT_W      = cnt_bits(max3(RST_HOLD, CLK_SETTLE, QTIMEOUT))
) (
  input  logic       EXTCLK,
  input  logic       EXTRST,
  input  logic       power_req,
  input  logic       soft_rst,
  input  logic       quiesce_ack,
  input  logic       timeout_clr,
  output logic       rsten,
  output logic       clken,
  output logic       quiesce_req,
  output logic       ready,
  output logic       busy,
  output logic       timeout_flag,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(CLK_SETTLE);
  localparam logic [CNT_W-1:0] LD_QTMO   = CNT_W'(QTIMEOUT);

  rcu_state_e       state_q;
  rcu_state_e       state_nxt;
  rcu_ctl_t         ctl_q;
  rcu_ctl_t         ctl_nxt;
  logic             cnt_load;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_ld_val;
  logic             timeout_set;
  logic             tflag_q;

  rcu_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .EXTCLK   (EXTCLK),
    .EXTRST   (EXTRST),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .last     (cnt_last)
  );

  always_comb begin
    state_nxt   = state_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (power_req) state_nxt = ST_CLK_ON;
      end
      ST_CLK_ON: begin
        // Losing power before the hold completes aborts with reset still asserted.
        if (!power_req)    state_nxt = ST_CLK_STOP;
        else if (cnt_last) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!power_req || soft_rst) state_nxt = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if (quiesce_ack) begin
          state_nxt = ST_RST_ON;
        end else if (cnt_last) begin
          state_nxt   = ST_RST_ON;
          timeout_set = 1'b1;
        end
      end
      ST_RST_ON: begin
        if (cnt_last) state_nxt = power_req ? ST_CLK_ON : ST_CLK_STOP;
      end
      ST_CLK_STOP: begin
        if (cnt_last) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Counter is reloaded on every state entry with the new state's dwell time.
  always_comb begin
    cnt_load   = (state_nxt != state_q);
    cnt_ld_val = '0;
    case (state_nxt)
      ST_CLK_ON,
      ST_RST_ON:   cnt_ld_val = LD_HOLD;
      ST_QUIESCE:  cnt_ld_val = LD_QTMO;
      ST_CLK_STOP: cnt_ld_val = LD_SETTLE;
      default:     cnt_ld_val = '0;
    endcase
  end

  assign ctl_nxt = state_ctl(state_nxt);

  always_ff @(posedge EXTCLK) begin
    if (EXTRST) begin
      state_q <= ST_OFF;
      ctl_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ctl_q   <= ctl_nxt;
      // A timeout in the same cycle as a clear wins so the event is never lost.
      if (timeout_set)      tflag_q <= 1'b1;
      else if (timeout_clr) tflag_q <= 1'b0;
    end
  end

  assign rsten        = ctl_q.rsten;
  assign clken        = ctl_q.clken;
  assign quiesce_req  = ctl_q.quiesce_req;
  assign ready        = ctl_q.ready;
  assign busy         = ctl_q.busy;
  assign timeout_flag = tflag_q;
  assign state        = state_q;

endmodule

// File: tb/tb_rcu_seq.sv
// Bench for rcu_seq: directed sequence followed by randomized episodes against a phase-timeline model.
module tb_rcu_seq;
  import rcu_pkg::*;

  localparam int RH = 4;
  localparam int CS = 2;
  localparam int QT = 255;

  logic       EXTCLK;
  logic       EXTRST;
  logic       power_req;
  logic       soft_rst;
  logic       quiesce_ack;
  logic       timeout_clr;
  logic       rsten;
  logic       clken;
  logic       quiesce_req;
  logic       ready;
  logic       busy;
  logic       timeout_flag;
  logic [2:0] state;

  int   n_assert;
  int   n_fail;
  int   cyc;
  bit   rnd_en;
  logic exp_flag;
  bit   have_prev;
  logic prev_rsten;
  logic prev_clken;

  rcu_seq #(
    .RST_HOLD   (RH),
    .CLK_SETTLE (CS),
    .QTIMEOUT   (QT),
    .CNT_W      (8)
  ) dut (
    .EXTCLK       (EXTCLK),
    .EXTRST       (EXTRST),
    .power_req    (power_req),
    .soft_rst     (soft_rst),
    .quiesce_ack  (quiesce_ack),
    .timeout_clr  (timeout_clr),
    .rsten        (rsten),
    .clken        (clken),
    .quiesce_req  (quiesce_req),
    .ready        (ready),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .state        (state)
  );

  initial begin
    EXTCLK = 1'b0;
    forever #5 EXTCLK = ~EXTCLK;
  end

  // Output table per state: {rsten, clken, quiesce_req, ready, busy}.
  function automatic logic [4:0] exp_ctl(input rcu_state_e st);
    case (st)
      ST_CLK_ON:   return 5'b01001;
      ST_RUN:      return 5'b11010;
      ST_QUIESCE:  return 5'b11101;
      ST_RST_ON:   return 5'b01001;
      ST_CLK_STOP: return 5'b00001;
      default:     return 5'b00000;
    endcase
  endfunction

  task automatic tick();
    @(posedge EXTCLK);
    #1;
    cyc++;
  endtask

  task automatic check(input rcu_state_e st);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {state, rsten, clken, quiesce_req, ready, busy, timeout_flag};
    exp = {st, exp_ctl(st), exp_flag};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed={st,rst,clk,qrq,rdy,bsy,flg}=%b expected=%b",
             st.name(), cyc, obs, exp);
    end
    n_assert++;
    assert (!(rsten === 1'b1 && clken !== 1'b1)) else begin
      n_fail++;
      $error("FAIL rsten_without_clken cyc=%0d observed rsten=%b clken=%b expected clken=1", cyc, rsten, clken);
    end
    if (have_prev) begin
      n_assert++;
      assert (!(prev_rsten && prev_clken && !rsten && !clken)) else begin
        n_fail++;
        $error("FAIL clken_fell_with_rsten cyc=%0d observed clken=%b expected 1", cyc, clken);
      end
    end
    prev_rsten = rsten;
    prev_clken = clken;
    have_prev  = 1'b1;
  endtask

  // Spend n cycles in state st. Inputs on the final cycle select the exit; side inputs are randomized when rnd_en.
  task automatic phase(input rcu_state_e st, input int n, input int pwr_body, input bit pwr_last,
                       input bit soft_last, input bit ack_last, input bit tmo, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      bit last;
      bit clr;
      last = (i == n - 1);
      check(st);
      if (last)               power_req = pwr_last;
      else if (pwr_body == 2) power_req = 1'($urandom_range(0, 1));
      else                    power_req = (pwr_body != 0);
      if (st == ST_RUN) soft_rst = last && soft_last;
      else              soft_rst = rnd_en && ($urandom_range(0, 2) == 0);
      if (st == ST_QUIESCE) quiesce_ack = last && ack_last;
      else                  quiesce_ack = rnd_en && ($urandom_range(0, 1) == 1);
      clr = (last && clr_last) || (rnd_en && ($urandom_range(0, 7) == 0));
      timeout_clr = clr;
      tick();
      if (tmo && last) exp_flag = 1'b1;
      else if (clr)    exp_flag = 1'b0;
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; rnd_en = 1'b0;
    exp_flag = 1'b0; have_prev = 1'b0; prev_rsten = 1'b0; prev_clken = 1'b0;
    EXTRST = 1'b1; power_req = 1'b0; soft_rst = 1'b0; quiesce_ack = 1'b0; timeout_clr = 1'b0;
    repeat (2) tick();
    EXTRST = 1'b0;

    // Power-up: clken at cycle 1, rsten/ready at cycle 1+RH.
    phase(ST_OFF,     1,  0, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,  RH, 1, 1, 0, 0, 0, 0);
    phase(ST_RUN,     3,  1, 1, 0, 0, 0, 0);

    // Power-down with ack on the third quiesce cycle; power_req wiggle in CLK_STOP is ignored.
    phase(ST_RUN,      1,  1, 0, 0, 0, 0, 0);
    phase(ST_QUIESCE,  3,  0, 0, 0, 1, 0, 0);
    phase(ST_RST_ON,   RH, 0, 0, 0, 0, 0, 0);
    phase(ST_CLK_STOP, CS, 1, 1, 0, 0, 0, 0);
    phase(ST_OFF,      2,  0, 0, 0, 0, 0, 0);

    // Abort on the second CLK_ON cycle.
    phase(ST_OFF,      1,  0, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,   2,  1, 0, 0, 0, 0, 0);
    phase(ST_CLK_STOP, CS, 0, 0, 0, 0, 0, 0);
    phase(ST_OFF,      1,  0, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_RUN,      2,  1, 1, 0, 0, 0, 0);

    // soft_rst with ack already high: one quiesce cycle, reset pulse, clock kept.
    phase(ST_RUN,      1,  1, 1, 1, 0, 0, 0);
    phase(ST_QUIESCE,  1,  1, 1, 0, 1, 0, 0);
    phase(ST_RST_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_RUN,      2,  1, 1, 0, 0, 0, 0);

    // Quiesce timeout, then clear the flag.
    phase(ST_RUN,      1,  1, 1, 1, 0, 0, 0);
    phase(ST_QUIESCE,  QT, 1, 1, 0, 0, 1, 0);
    phase(ST_RST_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_RUN,      1,  1, 1, 0, 0, 0, 1);
    phase(ST_RUN,      1,  1, 1, 0, 0, 0, 0);

    // Timeout coinciding with a clear; soft_rst together with power-down takes the power-down path.
    phase(ST_RUN,      1,  1, 0, 1, 0, 0, 0);
    phase(ST_QUIESCE,  QT, 0, 0, 0, 0, 1, 1);
    phase(ST_RST_ON,   RH, 0, 0, 0, 0, 0, 0);
    phase(ST_CLK_STOP, CS, 0, 0, 0, 0, 0, 0);
    phase(ST_OFF,      1,  0, 1, 0, 0, 0, 0);
    phase(ST_CLK_ON,   RH, 1, 1, 0, 0, 0, 0);
    phase(ST_RUN,      2,  1, 1, 0, 0, 0, 0);

    // Synchronous reset mid-RUN clears everything including the sticky flag.
    EXTRST = 1'b1;
    repeat (2) tick();
    EXTRST = 1'b0;
    power_req = 1'b0;
    exp_flag  = 1'b0;
    have_prev = 1'b0;
    phase(ST_OFF, 2, 0, 0, 0, 0, 0, 0);

    rnd_en = 1'b1;
    for (int e = 0; e < 40; e++) begin
      int idle;
      int j;
      int laps;
      idle = $urandom_range(1, 3);
      phase(ST_OFF, idle, 0, 1, 0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(1, RH);
        phase(ST_CLK_ON,   j,  1, 0, 0, 0, 0, 0);
        phase(ST_CLK_STOP, CS, 2, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      end else begin
        phase(ST_CLK_ON, RH, 1, 1, 0, 0, 0, 0);
        laps = $urandom_range(1, 3);
        for (int l = 0; l < laps; l++) begin
          int k;
          int d;
          int ev;
          k  = $urandom_range(1, 5);
          d  = $urandom_range(1, 6);
          ev = (l == laps - 1) ? $urandom_range(1, 2) : 0;
          phase(ST_RUN,     k,  1, (ev == 0), (ev != 1), 0, 0, 0);
          phase(ST_QUIESCE, d,  2, 1'($urandom_range(0, 1)), 0, 1, 0, 0);
          phase(ST_RST_ON,  RH, 2, (ev == 0), 0, 0, 0, 0);
          if (ev == 0) phase(ST_CLK_ON,   RH, 1, 1, 0, 0, 0, 0);
          else         phase(ST_CLK_STOP, CS, 2, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
